sram_burst_ctrl: RTL and testbench
==================================

// Module: sram_burst_ctrl
// PURPOSE
// - Initiator for the single-port unified-buffer SRAM (1-cycle registered read, write-priority port).
// - Accepts burst commands (write or read, start address, length) and streams words with valid/ready.
// - Absorbs the SRAM read latency and rd-side backpressure through a small output FIFO.
// - Sits between the systolic-array datapath/loader and the SRAM instance.
// PARAMETERS
// - ADDRESSSIZE  10      SRAM address width; depth = 2**ADDRESSSIZE words
// - WORDSIZE     8*20    SRAM word width in bits
// - LENW         ADDRESSSIZE+1  burst length width; max len = 2**ADDRESSSIZE
// PORTS
// - clk          in   1            single clock, all logic posedge
// - rst_n        in   1            asynchronous, active-low reset
// - cmd_valid    in   1            command offered
// - cmd_ready    out  1            command accepted when valid&ready
// - cmd_write    in   1            1 = write burst, 0 = read burst
// - cmd_addr     in   ADDRESSSIZE  start address
// - cmd_len      in   LENW         number of words; 0 = no-op
// - wr_valid     in   1            write word offered
// - wr_ready     out  1            write word consumed when valid&ready
// - wr_data      in   WORDSIZE     write word
// - rd_valid     out  1            read word available
// - rd_ready     in   1            read word consumed when valid&ready
// - rd_data      out  WORDSIZE     read word
// - busy         out  1            burst in progress (state != IDLE)
// - done         out  1            one-cycle pulse: burst complete
// - sram_we      out  1            to SRAM write_enable
// - sram_addr    out  ADDRESSSIZE  to SRAM address
// - sram_din     out  WORDSIZE     to SRAM data_in
// - sram_dout    in   WORDSIZE     from SRAM data_out (valid cycle after a read issue)
// BEHAVIOUR
// - Reset: state IDLE, FIFO empty, pending=0, addr/remaining=0. Outputs: cmd_ready=1, wr_ready=0,
//   rd_valid=0, busy=0, done=0, sram_we=0, sram_addr=0; rd_data/sram_din don't-care.
// - FSM IDLE/WRITE/READ. cmd_ready = (state==IDLE). Handshake latches addr=cmd_addr, remaining=cmd_len.
//   len!=0: ->WRITE or ->READ. len==0: stay IDLE, done=1 next cycle, no SRAM access.
// - WRITE: wr_ready=1; sram_we = wr_valid, sram_addr = addr, sram_din = wr_data (combinational).
//   Per handshake: addr+1, remaining-1. Last handshake (remaining==1) -> IDLE, done=1 next cycle.
// - READ: issue when remaining!=0 and fifo_count+pending < 3: sram_we=0, sram_addr=addr; addr+1,
//   remaining-1, pending<=1 (else pending<=0). pending=1 pushes sram_dout into FIFO that cycle.
//   rd_valid = FIFO non-empty, rd_data = FIFO head. Exit ->IDLE when remaining==0, pending==0,
//   FIFO empty; done=1 in the IDLE cycle after exit.
// - Latency: read cmd handshake in cycle 0 -> first issue cycle 1 -> push cycle 2 -> rd_valid cycle 3.
//   With rd_ready held 1, sustained 1 word/cycle. Write: 1 word/cycle while wr_valid held 1.
// - Address wraps modulo 2**ADDRESSSIZE (1023+1 -> 0); len 2**ADDRESSSIZE covers whole array once.
// - Outside WRITE, sram_we=0 always; SRAM reads in idle cycles are ignored (pending=0).
// - done and cmd_ready may both be 1 in one cycle; a new command may be accepted then.
// - cmd_valid, wr_valid outside their states: ignored; no words consumed.
// - Reset mid-burst: abort immediately, FIFO flushed, no done pulse; words already written stay
//   in SRAM (SRAM has no reset).
// STRUCTURE
// - Shared package sram_ctrl_pkg: state encoding (IDLE=0, WRITE=1, READ=2), RD_FIFO_DEPTH=3.
// - Sub-module sram_rd_fifo: 3-entry, WORDSIZE-wide sync FIFO with count, same clk/rst_n;
//   push/pop same cycle allowed when non-empty; flush on reset.
// - Top: FSM, address/remaining counters, pending flag, credit check, done register.
// TESTING
// - Write len=4 at addr 1022, data A,B,C,D, wr_valid held 1 -> sram_we 4 cycles, addrs 1022,1023,0,1;
//   done 1 cycle after last.
// - Read back len=4 at 1022, rd_ready=1 -> rd_valid cycle 3 after handshake, A,B,C,D consecutive, then done.
// - Read len=8 with rd_ready toggling 1/0 -> no word lost/duplicated, in order, never >3 outstanding.
// - Write len=3 with wr_valid gaps (1,0,0,1,0,1) -> exactly 3 SRAM writes, done after third.
// - cmd_len=0 (both directions) -> no sram_we, no rd_valid, done=1 next cycle, cmd_ready stays 1.
// - Assert rst_n low mid read burst (after 2 words) -> next cycle rd_valid=0, busy=0, cmd_ready=1,
//   no done; subsequent read returns correct data.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller: FSM encoding and read-FIFO sizing.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam int RD_FIFO_DEPTH = 3;
  localparam int RD_CNT_W      = $clog2(RD_FIFO_DEPTH + 1);

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Command, write-stream, read-stream, status and SRAM-side signals of the burst controller.
interface sram_burst_ctrl_if #(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 8 * 20,
  parameter int LENW        = ADDRESSSIZE + 1
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [ADDRESSSIZE-1:0] cmd_addr;
  logic [LENW-1:0]        cmd_len;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [WORDSIZE-1:0]    wr_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [WORDSIZE-1:0]    rd_data;
  logic                   busy;
  logic                   done;
  logic                   sram_we;
  logic [ADDRESSSIZE-1:0] sram_addr;
  logic [WORDSIZE-1:0]    sram_din;
  logic [WORDSIZE-1:0]    sram_dout;

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, sram_dout,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, sram_we, sram_addr, sram_din
  );

  // Datapath/loader plus SRAM side.
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, sram_dout,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, sram_we, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_rd_fifo.sv
// Small synchronous FIFO that absorbs SRAM read latency and read-side backpressure.
module sram_rd_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WORDSIZE = 8 * 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic [WORDSIZE-1:0] push_data_i,
  input  logic                pop_i,
  output logic [WORDSIZE-1:0] head_o,
  output logic [RD_CNT_W-1:0] count_o,
  output logic                empty_o
);

  logic [WORDSIZE-1:0] mem_q [RD_FIFO_DEPTH];
  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  logic [RD_CNT_W-1:0] count_q, count_d;
  logic                do_push, do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(RD_FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
  assign do_push = push_i & ((count_q != RD_CNT_W'(RD_FIFO_DEPTH)) | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + RD_CNT_W'(1);
      2'b01:   count_d = count_q - RD_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst initiator for the single-port unified-buffer SRAM: write bursts stream straight through,
// read bursts are credit-limited so the 1-cycle SRAM latency never overruns the output FIFO.
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 8 * 20,
  parameter int LENW        = ADDRESSSIZE + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  sram_burst_ctrl_if.slave bus
);

  state_e                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] addr_q, addr_d;
  logic [LENW-1:0]        rem_q, rem_d;
  logic                   pending_q, pending_d;
  logic                   done_q, done_d;

  logic [RD_CNT_W-1:0]    fifo_count;
  logic [WORDSIZE-1:0]    fifo_head;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [2:0]             inflight;
  logic                   credit_ok;

  // Words in the FIFO plus the one returning from the SRAM must fit in the FIFO.
  assign inflight  = {1'b0, fifo_count} + {2'b00, pending_q};
  assign credit_ok = (inflight < 3'(RD_FIFO_DEPTH));
  assign fifo_pop  = ~fifo_empty & bus.rd_ready;

  assign bus.rd_valid = ~fifo_empty;
  assign bus.rd_data  = fifo_head;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    pending_d     = 1'b0;
    done_d        = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.sram_we   = 1'b0;
    bus.sram_addr = addr_q;
    bus.sram_din  = bus.wr_data;
    case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          rem_d  = bus.cmd_len;
          if (bus.cmd_len == '0) done_d  = 1'b1;
          else                   state_d = bus.cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        bus.wr_ready = 1'b1;
        bus.sram_we  = bus.wr_valid;
        if (bus.wr_valid) begin
          addr_d = addr_q + ADDRESSSIZE'(1);
          rem_d  = rem_q - LENW'(1);
          if (rem_q == LENW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if ((rem_q != '0) && credit_ok) begin
          addr_d    = addr_q + ADDRESSSIZE'(1);
          rem_d     = rem_q - LENW'(1);
          pending_d = 1'b1;
        end else if ((rem_q == '0) && !pending_q && fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  sram_rd_fifo #(.WORDSIZE(WORDSIZE)) u_rd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (pending_q),
    .push_data_i (bus.sram_dout),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with an SRAM model, a reference memory and a per-cycle scoreboard.
module tb_sram_burst_ctrl;
  localparam int AW = 10;
  localparam int WS = 160;
  localparam int LW = 11;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   rd_mode = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   notready_cnt = 0;

  logic [WS-1:0] sram_mem [DEPTH];
  logic [WS-1:0] ref_mem  [DEPTH];

  logic [WS-1:0] exp_rd[$];
  int            exp_wr_addr[$];
  logic [WS-1:0] exp_wr_data[$];
  int            wr_cyc_log[$];
  int            wr_addr_log[$];
  int            rd_cyc_log[$];
  int            rdv_log[$];
  int            done_log[$];

  sram_burst_ctrl_if #(.ADDRESSSIZE(AW), .WORDSIZE(WS), .LENW(LW)) bus ();

  sram_burst_ctrl #(.ADDRESSSIZE(AW), .WORDSIZE(WS), .LENW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM: registered read, write wins the port.
  always @(posedge clk) begin
    if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_din;
    bus.sram_dout <= sram_mem[bus.sram_addr];
  end

  initial begin
    bus.rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_mode == 0) bus.rd_ready = 1'b1;
      else              bus.rd_ready = ~bus.rd_ready;
    end
  end

  task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every SRAM write and every consumed read word against the reference.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("cmd_ready_is_not_busy", bus.cmd_ready, !bus.busy);
      if (bus.sram_we) begin
        wr_cyc_log.push_back(cyc);
        wr_addr_log.push_back(int'(bus.sram_addr));
        chk("write_was_expected", exp_wr_addr.size() > 0, 1'b1);
        if (exp_wr_addr.size() > 0) begin
          chk("sram_addr", bus.sram_addr, exp_wr_addr.pop_front());
          chk("sram_din", bus.sram_din, exp_wr_data.pop_front());
        end
      end
      if (bus.rd_valid) rdv_log.push_back(cyc);
      if (bus.rd_valid && bus.rd_ready) begin
        rd_cyc_log.push_back(cyc);
        chk("read_was_expected", exp_rd.size() > 0, 1'b1);
        if (exp_rd.size() > 0) chk("rd_data", bus.rd_data, exp_rd.pop_front());
      end
      if (bus.done) done_log.push_back(cyc);
      if (!bus.cmd_ready) notready_cnt++;
    end
  end

  task automatic clear_logs();
    wr_cyc_log.delete();
    wr_addr_log.delete();
    rd_cyc_log.delete();
    rdv_log.delete();
    done_log.delete();
    notready_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
  task automatic send_cmd(input logic w, input int a, input int l, output int h);
    h = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = AW'(a);
    bus.cmd_len   = LW'(l);
    for (int g = 0; g < 50 && h < 0; g++) begin
      @(negedge clk);
      if (bus.cmd_ready) h = cyc;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accepted", h >= 0, 1'b1);
  endtask

  task automatic write_burst(input int a, input int l, input logic [15:0] pat, input int patlen,
                             output int h);
    logic [WS-1:0] wdata[$];
    int idx;
    int p;
    for (int k = 0; k < l; k++) begin
      logic [WS-1:0] d;
      d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      wdata.push_back(d);
      exp_wr_addr.push_back((a + k) % DEPTH);
      exp_wr_data.push_back(d);
      ref_mem[(a + k) % DEPTH] = d;
    end
    send_cmd(1'b1, a, l, h);
    idx = 0;
    p = 0;
    for (int g = 0; g < 300 && idx < l; g++) begin
      bus.wr_valid = (p < patlen) ? pat[p] : 1'b1;
      bus.wr_data  = wdata[idx];
      @(negedge clk);
      if (bus.wr_valid && bus.wr_ready) idx++;
      p++;
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    chk("write_burst_complete", idx, l);
  endtask

  task automatic read_burst(input int a, input int l, output int h);
    int g;
    for (int k = 0; k < l; k++) exp_rd.push_back(ref_mem[(a + k) % DEPTH]);
    send_cmd(1'b0, a, l, h);
    g = 0;
    while (!(exp_rd.size() == 0 && done_log.size() > 0) && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("read_burst_finished", exp_rd.size() == 0 && done_log.size() > 0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit expected end of test");
    $fatal(1);
  end

  initial begin
    int h, h2, g;
    int exp_addrs[4];
    exp_addrs = '{1022, 1023, 0, 1};
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 1'b1);
    chk("reset_wr_ready", bus.wr_ready, 1'b0);
    chk("reset_rd_valid", bus.rd_valid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_sram_we", bus.sram_we, 1'b0);
    chk("reset_sram_addr", bus.sram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Write across the top of the address space.
    clear_logs();
    write_burst(1022, 4, 16'hFFFF, 16, h);
    idle(3);
    chk("t1_write_count", wr_cyc_log.size(), 4);
    chk("t1_first_write_cycle", wr_cyc_log[0], h + 1);
    chk("t1_last_write_cycle", wr_cyc_log[3], h + 4);
    for (int i = 0; i < 4; i++) chk("t1_write_addr", wr_addr_log[i], exp_addrs[i]);
    chk("t1_done_count", done_log.size(), 1);
    chk("t1_done_cycle", done_log[0], h + 5);

    // Read it back with rd_ready held high.
    clear_logs();
    read_burst(1022, 4, h);
    idle(2);
    chk("t2_read_count", rd_cyc_log.size(), 4);
    chk("t2_first_valid_cycle", rdv_log[0], h + 3);
    chk("t2_valid_cycles", rdv_log.size(), 4);
    chk("t2_last_read_cycle", rd_cyc_log[3], h + 6);
    chk("t2_done_count", done_log.size(), 1);
    chk("t2_done_cycle", done_log[0], h + 8);

    // Eight words under toggling backpressure.
    clear_logs();
    write_burst(1020, 8, 16'hFFFF, 16, h);
    idle(2);
    clear_logs();
    rd_mode = 1;
    read_burst(1020, 8, h);
    rd_mode = 0;
    idle(2);
    chk("t3_read_count", rd_cyc_log.size(), 8);
    chk("t3_done_count", done_log.size(), 1);
    chk("t3_done_after_last", done_log[0] > rd_cyc_log[7], 1'b1);

    // Write with wr_valid gaps 1,0,0,1,0,1.
    clear_logs();
    write_burst(500, 3, 16'h0029, 6, h);
    idle(3);
    chk("t4_write_count", wr_cyc_log.size(), 3);
    chk("t4_write0_cycle", wr_cyc_log[0], h + 1);
    chk("t4_write1_cycle", wr_cyc_log[1], h + 4);
    chk("t4_write2_cycle", wr_cyc_log[2], h + 6);
    chk("t4_done_cycle", done_log[0], h + 7);
    clear_logs();
    read_burst(500, 3, h);
    idle(2);
    chk("t4_readback_count", rd_cyc_log.size(), 3);

    // Zero-length commands, back to back, with a stray wr_valid.
    clear_logs();
    bus.wr_valid = 1'b1;
    send_cmd(1'b1, 10, 0, h);
    send_cmd(1'b0, 20, 0, h2);
    idle(3);
    bus.wr_valid = 1'b0;
    chk("t5_accept_in_done_cycle", h2, h + 1);
    chk("t5_done_count", done_log.size(), 2);
    chk("t5_done0_cycle", done_log[0], h + 1);
    chk("t5_done1_cycle", done_log[1], h2 + 1);
    chk("t5_no_writes", wr_cyc_log.size(), 0);
    chk("t5_no_rd_valid", rdv_log.size(), 0);
    chk("t5_cmd_ready_held", notready_cnt, 0);

    // Reset after two words of a read burst.
    clear_logs();
    for (int k = 0; k < 8; k++) exp_rd.push_back(ref_mem[(1020 + k) % DEPTH]);
    send_cmd(1'b0, 1020, 8, h);
    g = 0;
    while (rd_cyc_log.size() < 2 && g < 100) begin
      @(posedge clk);
      g++;
    end
    chk("t6_two_words_before_reset", rd_cyc_log.size(), 2);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rd_valid", bus.rd_valid, 1'b0);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_cmd_ready", bus.cmd_ready, 1'b1);
    chk("t6_done", bus.done, 1'b0);
    exp_rd.delete();
    @(negedge clk);
    chk("t6_done_held_low", bus.done, 1'b0);
    rst_n = 1'b1;
    chk("t6_no_done_pulse", done_log.size(), 0);
    idle(1);
    clear_logs();
    read_burst(1020, 4, h);
    idle(2);
    chk("t6_read_count", rd_cyc_log.size(), 4);
    chk("t6_done_count", done_log.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
